// File: rtl/dtree_pkg.sv
// Shared types and sizing for the decision-tree node walker.
package dtree_pkg;

  localparam int N_FEAT    = 16;
  localparam int FEAT_W    = 8;
  localparam int FIDX_W    = 4;
  localparam int CLASS_W   = 4;
  localparam int NODE_AW   = 6;
  localparam int MAX_STEPS = 16;

  localparam int STEP_W   = $clog2(MAX_STEPS);
  localparam int NODE_W   = 1 + FIDX_W + FEAT_W + NODE_AW;
  localparam int N_NODES  = 1 << NODE_AW;
  localparam int SAMPLE_W = N_FEAT * FEAT_W;

  // Field order matches the config word layout {is_leaf, fidx, thr, right}.
  typedef struct packed {
    logic               is_leaf;
    logic [FIDX_W-1:0]  fidx;
    logic [FEAT_W-1:0]  thr;
    logic [NODE_AW-1:0] right;
  } node_t;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  // Cleared table entry: a leaf that predicts class 0.
  localparam node_t LEAF0 = '{is_leaf: 1'b1, default: '0};

endpackage

// File: rtl/dtree_node_walker_if.sv
// Config, sample-in and class-out signals of the node walker.
interface dtree_node_walker_if;
  import dtree_pkg::*;

  logic                cfg_we;
  logic [NODE_AW-1:0]  cfg_addr;
  logic [NODE_W-1:0]   cfg_wdata;
  logic                cfg_busy;

  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_feat;

  logic                out_valid;
  logic                out_ready;
  logic [CLASS_W-1:0]  out_class;
  logic                out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    input  cfg_busy, in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
    output cfg_busy, in_ready, out_valid, out_class, out_err
  );

endinterface

// File: rtl/dtree_node_cmp.sv
// Evaluates one tree node against the latched sample: picks the feature,
// does the unsigned "feature <= threshold" test and produces the next pointer.
module dtree_node_cmp
  import dtree_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  input  node_t               node,
  input  logic [NODE_AW-1:0]  ptr,
  output logic                is_leaf,
  output logic [CLASS_W-1:0]  cls,
  output logic [NODE_AW-1:0]  next_ptr,
  output logic                bad_idx
);

  logic [FEAT_W-1:0] feats [N_FEAT];
  logic [FEAT_W-1:0] feat;

  assign is_leaf = node.is_leaf;
  assign cls     = node.thr[CLASS_W-1:0];
  assign bad_idx = !node.is_leaf && (int'(node.fidx) >= N_FEAT);

  // Unpack the flat sample vector into per-feature lanes.
  always_comb begin
    for (int k = 0; k < N_FEAT; k++) begin
      feats[k] = sample[k*FEAT_W +: FEAT_W];
    end
  end

  // Left child is the next preorder entry; wraps modulo table size.
  always_comb begin
    feat     = bad_idx ? '0 : feats[node.fidx];
    next_ptr = (feat <= node.thr) ? (ptr + NODE_AW'(1)) : node.right;
  end

endmodule

// File: rtl/dtree_node_walker.sv
// Sequential decision-tree engine: one node per cycle from a programmable
// table, one sample in flight, result held until the consumer takes it.
//
// state | meaning
// IDLE  | accepting a sample and config writes
// WALK  | visiting one node per cycle
// DONE  | result presented, waiting for out_ready
module dtree_node_walker
  import dtree_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  dtree_node_walker_if.slave bus
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  state_t              state_q, state_d;
  node_t               table_q [N_NODES];
  logic [SAMPLE_W-1:0] sample_q;
  logic [NODE_AW-1:0]  ptr_q;
  logic [STEP_W-1:0]   steps_q;
  logic [CLASS_W-1:0]  out_class_q;
  logic                out_err_q;
  logic                out_valid_q;

  node_t               cur_node;
  logic                is_leaf;
  logic                bad_idx;
  logic [CLASS_W-1:0]  cls;
  logic [NODE_AW-1:0]  next_ptr;
  logic                abort;

  assign cur_node = table_q[ptr_q];
  assign abort    = bad_idx || (steps_q == LAST_STEP);

  dtree_node_cmp u_cmp (
    .sample   (sample_q),
    .node     (cur_node),
    .ptr      (ptr_q),
    .is_leaf  (is_leaf),
    .cls      (cls),
    .next_ptr (next_ptr),
    .bad_idx  (bad_idx)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.cfg_busy  = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_err   = out_err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = WALK;
      WALK:    if (is_leaf || abort) state_d = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Node table: writes land only while idle; reset returns every entry to leaf 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) table_q[i] <= LEAF0;
    end else if (state_q == IDLE && bus.cfg_we) begin
      table_q[bus.cfg_addr] <= node_t'(bus.cfg_wdata);
    end
  end

  // Sample capture, walk pointer/step counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      ptr_q       <= '0;
      steps_q     <= '0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sample_q <= bus.in_feat;
            ptr_q    <= '0;
            steps_q  <= '0;
          end
        end
        WALK: begin
          if (is_leaf) begin
            out_class_q <= cls;
            out_err_q   <= 1'b0;
          end else if (abort) begin
            out_class_q <= '0;
            out_err_q   <= 1'b1;
          end else begin
            ptr_q   <= next_ptr;
            steps_q <= steps_q + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // out_valid trails entry into DONE by one cycle and drops on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid_q <= 1'b0;
    else        out_valid_q <= (state_q == DONE) && !(out_valid_q && bus.out_ready);
  end

endmodule

// File: tb/tb_dtree_node_walker.sv
// Self-checking bench for dtree_node_walker: table-driven vectors plus
// hand-written sequences for backpressure, loop abort, dropped config
// writes and mid-walk reset. Expected results go through a scoreboard queue.
module tb_dtree_node_walker;
  import dtree_pkg::*;

  typedef struct {
    int cls;
    int err;
    int lat;
  } exp_t;

  typedef struct {
    logic [7:0] f3;
    int         cls;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t vecs[8];

  dtree_node_walker_if bus();

  dtree_node_walker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] inode(input int fidx, input int thr, input int right);
    return {1'b0, FIDX_W'(fidx), FEAT_W'(thr), NODE_AW'(right)};
  endfunction

  function automatic logic [NODE_W-1:0] leaf(input int c);
    return {1'b1, FIDX_W'(0), FEAT_W'(c), NODE_AW'(0)};
  endfunction

  function automatic logic [SAMPLE_W-1:0] rand_feat(input int idx, input int val);
    logic [SAMPLE_W-1:0] f;
    for (int k = 0; k < N_FEAT; k++) f[k*FEAT_W +: FEAT_W] = FEAT_W'($urandom_range(0, 255));
    f[idx*FEAT_W +: FEAT_W] = FEAT_W'(val);
    return f;
  endfunction

  task automatic cfg_write(input int addr, input logic [NODE_W-1:0] w);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = NODE_AW'(addr);
    bus.cfg_wdata = w;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  // Drives one sample, pushes its expectation, returns at the negedge
  // after the acceptance edge with in_feat scrambled.
  task automatic start_sample(input logic [SAMPLE_W-1:0] f, input int cls, input int err, input int lat);
    exp_t e;
    @(negedge clk);
    chk("in_ready_before_accept", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_feat  = f;
    e.cls = cls; e.err = err; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_feat  = rand_feat(0, $urandom_range(0, 255));
  endtask

  // Waits (bounded) for out_valid, n0 = cycles already elapsed since acceptance.
  task automatic wait_result(input string name, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!bus.out_valid) begin
      chk({name, "_timeout"}, n, e.lat);
      return;
    end
    chk({name, "_lat"}, n, e.lat);
    chk({name, "_class"}, int'(bus.out_class), e.cls);
    chk({name, "_err"}, int'(bus.out_err), e.err);
  endtask

  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_hs_valid_low"}, int'(bus.out_valid), 0);
    chk({name, "_hs_in_ready"}, int'(bus.in_ready), 1);
  endtask

  task automatic run_sample(input string name, input logic [SAMPLE_W-1:0] f, input int cls, input int err, input int lat);
    start_sample(f, cls, err, lat);
    wait_result(name, 0);
    handshake(name);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{8'd63, 5};
    vecs[1] = '{8'd64, 9};
    vecs[2] = '{8'd0, 5};
    vecs[3] = '{8'd255, 9};
    vecs[4] = '{8'd62, 5};
    vecs[5] = '{8'd65, 9};
    vecs[6] = '{8'd128, 9};
    vecs[7] = '{8'd17, 5};

    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_class", int'(bus.out_class), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_cfg_busy", int'(bus.cfg_busy), 0);

    // Cleared table: single leaf 0, two cycles.
    run_sample("empty_table", rand_feat(3, 7), 0, 0, 2);

    cfg_write(0, inode(3, 63, 2));
    cfg_write(1, leaf(5));
    cfg_write(2, leaf(9));

    for (int i = 0; i < 8; i++) begin
      run_sample($sformatf("vec%0d", i), rand_feat(3, int'(vecs[i].f3)), vecs[i].cls, 0, 3);
    end

    // Backpressure: result held, no new sample accepted.
    start_sample(rand_feat(3, 64), 9, 0, 3);
    wait_result("bp", 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_class", int'(bus.out_class), 9);
      chk("bp_err", int'(bus.out_err), 0);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    handshake("bp");

    // Self-loop aborts at the step limit.
    cfg_write(0, inode(0, 0, 0));
    run_sample("loop", rand_feat(0, 1), 0, 1, MAX_STEPS + 1);
    cfg_write(0, inode(3, 63, 2));
    run_sample("after_loop", rand_feat(3, 0), 5, 0, 3);

    // Config write during WALK is dropped.
    start_sample(rand_feat(3, 0), 5, 0, 3);
    chk("walk_cfg_busy", int'(bus.cfg_busy), 1);
    bus.cfg_we = 1'b1; bus.cfg_addr = NODE_AW'(1); bus.cfg_wdata = leaf(7);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    wait_result("drop", 1);
    handshake("drop");
    run_sample("drop_check", rand_feat(3, 10), 5, 0, 3);
    cfg_write(1, leaf(7));
    run_sample("idle_write", rand_feat(3, 10), 7, 0, 3);

    // Write and sample in the same IDLE cycle: walk sees the new entry.
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = NODE_AW'(1); bus.cfg_wdata = leaf(3);
    start_sample(rand_feat(3, 1), 3, 0, 3);
    bus.cfg_we = 1'b0;
    wait_result("same_cycle", 0);
    handshake("same_cycle");

    // Mid-walk reset kills the walk and clears the table.
    cfg_write(0, inode(0, 0, 0));
    start_sample(rand_feat(0, 1), 0, 1, MAX_STEPS + 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", int'(bus.out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    run_sample("post_rst", rand_feat(0, 1), 0, 0, 2);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
